// File: rtl/seq_pair_pkg.sv
// Shared state encodings and detector transition helpers for the serializing pair counter.
package seq_pair_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StReport = 2'd2
    } ctrl_state_e;

    typedef enum logic [2:0] {
        DetStart    = 3'd0,
        DetRd0Once  = 3'd1,
        DetRd0Twice = 3'd2,
        DetRd1Once  = 3'd3,
        DetRd1Twice = 3'd4
    } det_state_e;

    function automatic det_state_e det_next(input det_state_e s, input logic b);
        det_state_e n;
        if (b) begin
            n = (s == DetRd1Once || s == DetRd1Twice) ? DetRd1Twice : DetRd1Once;
        end else begin
            n = (s == DetRd0Once || s == DetRd0Twice) ? DetRd0Twice : DetRd0Once;
        end
        return n;
    endfunction

    // A hit is any move into a *Twice state: current bit repeats the previous one.
    function automatic logic det_hit(input det_state_e s, input logic b);
        logic h;
        if (b) begin
            h = (s == DetRd1Once || s == DetRd1Twice);
        end else begin
            h = (s == DetRd0Once || s == DetRd0Twice);
        end
        return h;
    endfunction

endpackage

// File: rtl/pair_detect.sv
// Mealy detector flagging two equal consecutive bits; holds state unless enabled.
module pair_detect
    import seq_pair_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic din_bit,
    output logic dout_bit
);

    det_state_e r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DetStart;
        end else if (clr) begin
            r_state <= DetStart;
        end else if (en) begin
            r_state <= det_next(r_state, din_bit);
        end
    end

    assign dout_bit = en & det_hit(r_state, din_bit);

endmodule

// File: rtl/seq_pair_ctrl.sv
// Accepts a word, shifts it MSB-first through the pair detector and reports the hit count.
module seq_pair_ctrl
    import seq_pair_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CNT_W = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              keep_hist,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              ser_bit,
    output logic              busy
);

    ctrl_state_e       r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [CNT_W-1:0]  r_hits;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_busy;

    logic w_accept;
    logic w_clr;
    logic w_en;
    logic w_ser_bit;
    logic w_hit;
    logic w_last;

    assign w_accept  = (r_state == StIdle) & in_valid;
    assign w_clr     = w_accept & ~keep_hist;
    assign w_en      = (r_state == StShift);
    assign w_ser_bit = w_en & r_shift[DATA_W-1];
    assign w_last    = (r_bitcnt == CNT_W'(DATA_W - 1));

    pair_detect u_pair_detect (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_clr),
        .en       (w_en),
        .din_bit  (w_ser_bit),
        .dout_bit (w_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_hits      <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_shift    <= in_data;
                        r_bitcnt   <= '0;
                        r_hits     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= StShift;
                    end
                end
                StShift: begin
                    r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 1'b1;
                    r_hits   <= r_hits + CNT_W'(w_hit);
                    // The final bit's hit is folded straight into the reported count.
                    if (w_last) begin
                        r_out_count <= r_hits + CNT_W'(w_hit);
                        r_out_valid <= 1'b1;
                        r_state     <= StReport;
                    end
                end
                StReport: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign ser_bit   = w_ser_bit;
    assign busy      = r_busy;

endmodule

// File: tb/tb_seq_pair_ctrl.sv
// Directed vector bench for seq_pair_ctrl with hand-computed hit counts.
module tb_seq_pair_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              keep_hist;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              ser_bit;
    logic              busy;

    int errors = 0;
    int checks = 0;

    seq_pair_ctrl #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .keep_hist (keep_hist),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .ser_bit   (ser_bit),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       keep;
        int         exp_cnt;
        int         hold;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // hold > 0 keeps out_ready low that many cycles while poking in_valid.
    task automatic run_word(input logic [7:0] d, input logic k, input int exp_cnt,
                            input int hold, input string name);
        logic [7:0] sb;
        int lat;
        bit seen;
        sb   = '0;
        lat  = 0;
        seen = 0;
        @(negedge clk);
        check({name, "_in_ready"}, int'(in_ready), 1);
        in_valid  = 1'b1;
        in_data   = d;
        keep_hist = k;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = 8'($urandom);
        keep_hist = 1'($urandom);
        check({name, "_busy"}, int'(busy), 1);
        check({name, "_rdy_low"}, int'(in_ready), 0);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (out_valid) begin
                seen = 1;
            end else begin
                if (lat < 8) sb[7-lat] = ser_bit;
                @(negedge clk);
                lat++;
            end
        end
        check({name, "_seen"}, int'(seen), 1);
        // Counted from the clock where in_valid is presented, result is DATA_W+1 clocks later.
        check({name, "_latency"}, lat + 1, DATA_W + 1);
        check({name, "_ser_bits"}, int'(sb), int'(d));
        check({name, "_count"}, int'(out_count), exp_cnt);
        for (int j = 0; j < hold; j++) begin
            in_valid = j[0];
            in_data  = 8'hFF;
            @(negedge clk);
            check({name, "_hold_valid"}, int'(out_valid), 1);
            check({name, "_hold_count"}, int'(out_count), exp_cnt);
            check({name, "_hold_rdy"}, int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_valid_drop"}, int'(out_valid), 0);
        check({name, "_rdy_back"}, int'(in_ready), 1);
        check({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int nres;
        int nacc;
        int times[2];
        int res[2];
        int stray;
        logic [7:0] words[2];

        tbl[0] = '{8'hFF, 1'b0, 7, 0};
        tbl[1] = '{8'hAA, 1'b0, 0, 0};
        tbl[2] = '{8'h33, 1'b0, 4, 5};
        tbl[3] = '{8'h01, 1'b0, 6, 0};
        tbl[4] = '{8'h80, 1'b1, 7, 0};
        tbl[5] = '{8'h01, 1'b0, 6, 0};
        tbl[6] = '{8'h80, 1'b0, 6, 0};
        tbl[7] = '{8'h00, 1'b1, 8, 0};
        tbl[8] = '{8'h55, 1'b1, 1, 0};
        tbl[9] = '{8'h0F, 1'b0, 6, 0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        keep_hist = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ser_bit", int'(ser_bit), 0);
        check("rst_out_count", int'(out_count), 0);

        for (int v = 0; v < 10; v++) begin
            run_word(tbl[v].data, tbl[v].keep, tbl[v].exp_cnt, tbl[v].hold,
                     $sformatf("vec%0d", v));
        end

        // Reset during the 4th SHIFT cycle of 8'hFF.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        keep_hist = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_ser_bit", int'(ser_bit), 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ser_bit", int'(ser_bit), 0);
        check("midrst_out_count", int'(out_count), 0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("midrst_no_result", stray, 0);
        check("midrst_in_ready", int'(in_ready), 1);
        run_word(8'hF0, 1'b1, 6, 0, "after_rst");

        // Back-to-back words with in_valid held high and out_ready tied high.
        words[0]  = 8'hFF;
        words[1]  = 8'h00;
        nres      = 0;
        nacc      = 0;
        out_ready = 1'b1;
        keep_hist = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (out_valid && nres < 2) begin
                times[nres] = cyc;
                res[nres]   = int'(out_count);
                nres++;
            end
            if (in_ready && nacc < 2) begin
                in_valid = 1'b1;
                in_data  = words[nacc];
                nacc++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", nres, 2);
        if (nres == 2) begin
            check("b2b_count0", res[0], 7);
            check("b2b_count1", res[1], 7);
            check("b2b_spacing", times[1] - times[0], DATA_W + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
